// File: rtl/biriscv_mul_arbiter.sv
// Shares one pipelined multiplier between the two issue slots and routes each result back to its slot.
// Optional build macro MUL_ARB_PERF_EN adds grant and conflict counters (perf_ops_o, perf_conflicts_o).
module biriscv_mul_arbiter #(
  parameter int MULT_STAGES = 2,
  parameter int RD_W        = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req0_valid_i,
  input  logic [RD_W-1:0] req0_rd_i,
  input  logic            req1_valid_i,
  input  logic [RD_W-1:0] req1_rd_i,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic [31:0]     mul_result_i,
  output logic            grant0_o,
  output logic            grant1_o,
  output logic            stall0_o,
  output logic            stall1_o,
  output logic            mul_valid_o,
  output logic            mul_sel_o,
  output logic            wb_valid_o,
  output logic            wb_slot_o,
  output logic [RD_W-1:0] wb_rd_o,
  output logic [31:0]     wb_value_o,
  output logic            busy_o
`ifdef MUL_ARB_PERF_EN
  ,
  output logic [31:0]     perf_ops_o,
  output logic [31:0]     perf_conflicts_o
`endif
);

  localparam int LAST = MULT_STAGES - 1;

  // Handshake: a slot holds reqN_valid_i until it sees grantN_o in the same
  // cycle; stallN_o tells it the request was not taken and must be re-presented.

  logic            rr_ptr;     // slot favoured on the next contested cycle
  logic            contested;
  logic            active;
  logic            issue_rd_sel;
  logic [RD_W-1:0] issue_rd;

  logic [MULT_STAGES-1:0] sh_valid;
  logic [MULT_STAGES-1:0] sh_slot;
  logic [RD_W-1:0]        sh_rd [MULT_STAGES];

  assign contested = req0_valid_i & req1_valid_i;
  assign active    = ~hold_i & ~flush_i;

  always_comb begin
    grant0_o = 1'b0;
    grant1_o = 1'b0;
    stall0_o = 1'b0;
    stall1_o = 1'b0;
    if (flush_i) begin
      // squash cycle: nothing issues and nobody is told to retry
    end else if (hold_i) begin
      stall0_o = req0_valid_i;
      stall1_o = req1_valid_i;
    end else if (contested) begin
      if (rr_ptr) begin
        grant1_o = 1'b1;
        stall0_o = 1'b1;
      end else begin
        grant0_o = 1'b1;
        stall1_o = 1'b1;
      end
    end else begin
      grant0_o = req0_valid_i;
      grant1_o = req1_valid_i;
    end
  end

  assign mul_valid_o  = grant0_o | grant1_o;
  assign mul_sel_o    = grant1_o;
  assign issue_rd_sel = grant1_o;
  assign issue_rd     = issue_rd_sel ? req1_rd_i : req0_rd_i;

  // Pointer only moves on a contested grant, so a lone requester never
  // steals the other slot's turn.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= 1'b0;
    end else if (active && contested) begin
      rr_ptr <= ~grant1_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_valid <= '0;
      sh_slot  <= '0;
      for (int i = 0; i < MULT_STAGES; i++) begin
        sh_rd[i] <= '0;
      end
    end else if (flush_i) begin
      sh_valid <= '0;
    end else if (!hold_i) begin
      sh_valid[0] <= mul_valid_o;
      sh_slot[0]  <= grant1_o;
      sh_rd[0]    <= issue_rd;
      for (int i = 1; i < MULT_STAGES; i++) begin
        sh_valid[i] <= sh_valid[i-1];
        sh_slot[i]  <= sh_slot[i-1];
        sh_rd[i]    <= sh_rd[i-1];
      end
    end
  end

  // A result emerging during a flush belongs to squashed work.
  assign wb_valid_o = sh_valid[LAST] & ~flush_i;
  assign wb_slot_o  = sh_slot[LAST];
  assign wb_rd_o    = sh_rd[LAST];
  assign wb_value_o = mul_result_i;
  assign busy_o     = |sh_valid;

`ifdef MUL_ARB_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_ops_o       <= '0;
      perf_conflicts_o <= '0;
    end else begin
      if (mul_valid_o) begin
        perf_ops_o <= perf_ops_o + 32'd1;
      end
      if (contested && !hold_i) begin
        perf_conflicts_o <= perf_conflicts_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_biriscv_mul_arbiter.sv
// Bench for biriscv_mul_arbiter: vector table for arbitration, scoreboard queue for writebacks.
module tb_biriscv_mul_arbiter;

  localparam int MS   = 2;
  localparam int RD_W = 5;
  localparam int QW   = 16 + 1 + RD_W;
  localparam int NV   = 19;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            req0_valid_i;
  logic [RD_W-1:0] req0_rd_i;
  logic            req1_valid_i;
  logic [RD_W-1:0] req1_rd_i;
  logic            hold_i;
  logic            flush_i;
  logic [31:0]     mul_result_i;
  logic            grant0_o;
  logic            grant1_o;
  logic            stall0_o;
  logic            stall1_o;
  logic            mul_valid_o;
  logic            mul_sel_o;
  logic            wb_valid_o;
  logic            wb_slot_o;
  logic [RD_W-1:0] wb_rd_o;
  logic [31:0]     wb_value_o;
  logic            busy_o;
`ifdef MUL_ARB_PERF_EN
  logic [31:0]     perf_ops_o;
  logic [31:0]     perf_conflicts_o;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  biriscv_mul_arbiter #(.MULT_STAGES(MS), .RD_W(RD_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req0_valid_i (req0_valid_i),
    .req0_rd_i    (req0_rd_i),
    .req1_valid_i (req1_valid_i),
    .req1_rd_i    (req1_rd_i),
    .hold_i       (hold_i),
    .flush_i      (flush_i),
    .mul_result_i (mul_result_i),
    .grant0_o     (grant0_o),
    .grant1_o     (grant1_o),
    .stall0_o     (stall0_o),
    .stall1_o     (stall1_o),
    .mul_valid_o  (mul_valid_o),
    .mul_sel_o    (mul_sel_o),
    .wb_valid_o   (wb_valid_o),
    .wb_slot_o    (wb_slot_o),
    .wb_rd_o      (wb_rd_o),
    .wb_value_o   (wb_value_o),
    .busy_o       (busy_o)
`ifdef MUL_ARB_PERF_EN
    ,
    .perf_ops_o       (perf_ops_o),
    .perf_conflicts_o (perf_conflicts_o)
`endif
  );

  typedef struct {
    logic            v0;
    logic [RD_W-1:0] rd0;
    logic            v1;
    logic [RD_W-1:0] rd1;
    logic            h;
    logic            f;
    logic            g0;
    logic            g1;
    logic            s0;
    logic            s1;
  } vec_t;

  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;

  // scoreboard entry: {due non-held cycle, slot, rd}
  logic [QW-1:0] exp_q[$];
  logic [15:0]   nh = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RD_W-1:0] rnd_rd();
    return RD_W'($urandom_range(0, 31));
  endfunction

  function automatic vec_t mk(input logic v0, input logic [RD_W-1:0] rd0,
                              input logic v1, input logic [RD_W-1:0] rd1,
                              input logic h, input logic f,
                              input logic g0, input logic g1,
                              input logic s0, input logic s1);
    vec_t v;
    v.v0 = v0; v.rd0 = rd0; v.v1 = v1; v.rd1 = rd1; v.h = h; v.f = f;
    v.g0 = g0; v.g1 = g1; v.s0 = s0; v.s1 = s1;
    return v;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input vec_t v);
    logic          exp_busy;
    logic          exp_wb;
    logic [QW-1:0] head;
    req0_valid_i = v.v0;
    req0_rd_i    = v.rd0;
    req1_valid_i = v.v1;
    req1_rd_i    = v.rd1;
    hold_i       = v.h;
    flush_i      = v.f;
    mul_result_i = $urandom;
    @(negedge clk_i);
    check("grant0", {31'd0, grant0_o}, {31'd0, v.g0});
    check("grant1", {31'd0, grant1_o}, {31'd0, v.g1});
    check("stall0", {31'd0, stall0_o}, {31'd0, v.s0});
    check("stall1", {31'd0, stall1_o}, {31'd0, v.s1});
    check("mul_valid", {31'd0, mul_valid_o}, {31'd0, v.g0 | v.g1});
    check("mul_sel", {31'd0, mul_sel_o}, {31'd0, v.g1});
    exp_busy = 1'b0;
    foreach (exp_q[i]) begin
      if (exp_q[i][QW-1 -: 16] < nh + 16'(MS)) exp_busy = 1'b1;
    end
    check("busy", {31'd0, busy_o}, {31'd0, exp_busy});
    exp_wb = 1'b0;
    if (!v.f && exp_q.size() > 0) exp_wb = (exp_q[0][QW-1 -: 16] == nh);
    check("wb_valid", {31'd0, wb_valid_o}, {31'd0, exp_wb});
    if (exp_wb) begin
      head = exp_q[0];
      check("wb_slot", {31'd0, wb_slot_o}, {31'd0, head[RD_W]});
      check("wb_rd", {27'd0, wb_rd_o}, {27'd0, head[RD_W-1:0]});
      check("wb_value", wb_value_o, mul_result_i);
      if (!v.h) void'(exp_q.pop_front());
    end
    if (v.g0 || v.g1) exp_q.push_back({nh + 16'(MS), v.g1, v.g1 ? v.rd1 : v.rd0});
    @(posedge clk_i);
    if (v.f) exp_q.delete();
    else if (!v.h) nh++;
    #1;
  endtask

  task automatic hs(input logic v0, input logic [RD_W-1:0] rd0,
                    input logic v1, input logic [RD_W-1:0] rd1,
                    input logic h, input logic f,
                    input logic g0, input logic g1,
                    input logic s0, input logic s1);
    cycle(mk(v0, rd0, v1, rd1, h, f, g0, g1, s0, s1));
  endtask

  task automatic idle();
    hs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant0"}, {31'd0, grant0_o}, 32'd0);
    check({tag, "_grant1"}, {31'd0, grant1_o}, 32'd0);
    check({tag, "_mul_valid"}, {31'd0, mul_valid_o}, 32'd0);
    check({tag, "_wb_valid"}, {31'd0, wb_valid_o}, 32'd0);
    check({tag, "_wb_slot"}, {31'd0, wb_slot_o}, 32'd0);
    check({tag, "_wb_rd"}, {27'd0, wb_rd_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    rst_ni       = 1'b0;
    req0_valid_i = 1'b0;
    req0_rd_i    = '0;
    req1_valid_i = 1'b0;
    req1_rd_i    = '0;
    hold_i       = 1'b0;
    flush_i      = 1'b0;
    mul_result_i = '0;

    // arbitration table, pointer starts at slot 0
    vecs[0]  = mk(1, 5'd5, 0, rnd_rd(), 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, rnd_rd(), 1, rnd_rd(), 0, 0, 1, 0, 0, 1);
    vecs[4]  = mk(1, rnd_rd(), 1, rnd_rd(), 0, 0, 0, 1, 1, 0);
    vecs[5]  = mk(1, rnd_rd(), 1, rnd_rd(), 0, 0, 1, 0, 0, 1);
    vecs[6]  = mk(1, rnd_rd(), 1, rnd_rd(), 0, 0, 0, 1, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, rnd_rd(), 1, rnd_rd(), 0, 0, 0, 1, 0, 0);
    vecs[10] = mk(1, rnd_rd(), 1, rnd_rd(), 0, 0, 1, 0, 0, 1);
    vecs[11] = mk(1, rnd_rd(), 1, rnd_rd(), 1, 0, 0, 0, 1, 1);
    vecs[12] = mk(1, rnd_rd(), 0, rnd_rd(), 1, 0, 0, 0, 1, 0);
    vecs[13] = mk(1, rnd_rd(), 1, rnd_rd(), 0, 0, 0, 1, 1, 0);
    vecs[14] = mk(1, rnd_rd(), 1, rnd_rd(), 0, 1, 0, 0, 0, 0);
    vecs[15] = mk(1, rnd_rd(), 0, rnd_rd(), 1, 1, 0, 0, 0, 0);
    vecs[16] = mk(1, rnd_rd(), 1, rnd_rd(), 0, 0, 1, 0, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    for (int i = 0; i < NV; i++) begin
      cycle(vecs[i]);
`ifdef MUL_ARB_PERF_EN
      if (i == 8) begin
        check("perf_ops", perf_ops_o, 32'd5);
        check("perf_conflicts", perf_conflicts_o, 32'd4);
      end
`endif
    end

    // grant, then two held cycles delay the writeback
    hs(1, 5'd17, 0, 0, 0, 0, 1, 0, 0, 0);
    hs(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    hs(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle();
    idle();

    // writeback present when hold rises stays put across the hold
    hs(0, 0, 1, 5'd20, 0, 0, 0, 1, 0, 0);
    idle();
    hs(1, 5'd3, 0, 0, 1, 0, 0, 0, 1, 0);
    hs(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle();

    // two ops in flight squashed by a flush, then a clean op
    hs(1, 5'd21, 0, 0, 0, 0, 1, 0, 0, 0);
    hs(0, 0, 1, 5'd22, 0, 0, 0, 1, 0, 0);
    hs(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle();
    hs(1, 5'd23, 0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    idle();

    // pointer is at slot 1 here; move it back to slot 1 via two contests
    hs(1, 5'd8, 1, 5'd9, 0, 0, 0, 1, 1, 0);
    hs(1, 5'd10, 1, 5'd11, 0, 0, 1, 0, 0, 1);
    idle();
    // asynchronous reset with work in flight
    rst_ni       = 1'b0;
    mul_result_i = '0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle();
    hs(1, 5'd12, 1, 5'd13, 0, 0, 1, 0, 0, 1);
    idle();
    idle();
    idle();

    check("leftover_expected", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
